// File: rtl/fpu_pkg.sv
// fpu_pkg: shared slot type, latency-class constants and default slot count
// for the FP writeback scheduler (fpu_wb_sched) and its hazard comparator.
package fpu_pkg;

  // Default number of writeback slots; the deepest latency is NSLOT-1.
  localparam int NSLOT = 4;

  // Slot rd fields are stored at this fixed width so the struct can live in
  // the package; register indices narrower than this are zero-extended.
  localparam int RW_MAX = 8;

  // Latency classes as presented on the lat input.
  typedef enum logic [1:0] {
    LAT_LOAD = 2'd0,
    LAT_ADSB = 2'd1,
    LAT_MULT = 2'd2,
    LAT_RSVD = 2'd3
  } lat_e;

  // One pending writeback: valid flag plus destination register.
  typedef struct packed {
    logic              v;
    logic [RW_MAX-1:0] rd;
  } slot_t;

endpackage

// File: rtl/fpu_hazard_cmp.sv
// fpu_hazard_cmp: compares one register index against every writeback slot
// and returns a per-slot match vector (only valid slots can match).
module fpu_hazard_cmp import fpu_pkg::*; #(
  parameter int NSLOT = fpu_pkg::NSLOT,
  parameter int RW    = 5
) (
  input  logic [RW-1:0]           idx_i,
  input  slot_t [NSLOT-1:0]       slots_i,
  output logic  [NSLOT-1:0]       match_o
);

  // A slot matches when it holds a live writeback to the same register.
  always_comb begin
    match_o = '0;
    for (int k = 0; k < NSLOT; k++) begin
      match_o[k] = slots_i[k].v && (slots_i[k].rd[RW-1:0] == idx_i);
    end
  end

endmodule

// File: rtl/fpu_wb_sched.sv
// fpu_wb_sched: FP writeback scheduler. A shift register of slots tracks
// when each accepted op writes back; issue is gated by structural, RAW and
// WAW hazards against those slots.
// Optional build macro FPU_SCHED_FWD_EN: a source matching the slot that is
// writing back this cycle is forwarded instead of stalling.
module fpu_wb_sched import fpu_pkg::*; #(
  parameter int NSLOT = fpu_pkg::NSLOT,
  parameter int RW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rd,
  input  logic [RW-1:0]   issue_rs1,
  input  logic [RW-1:0]   issue_rs2,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic            reg_write,
  input  logic [1:0]      lat,
  input  logic            flush,
  output logic            issue_ready,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [2**RW-1:0] busy
);

  slot_t [NSLOT-1:0] p_q, p_d;
  logic  [NSLOT-1:0] rs1Match, rs2Match, rdMatch;
  logic  [NSLOT-1:0] rawMask;
  logic              structHaz, rawHaz, wawHaz, accept;

  fpu_hazard_cmp #(.NSLOT(NSLOT), .RW(RW)) uCmpRs1 (
    .idx_i   (issue_rs1),
    .slots_i (p_q),
    .match_o (rs1Match)
  );

  fpu_hazard_cmp #(.NSLOT(NSLOT), .RW(RW)) uCmpRs2 (
    .idx_i   (issue_rs2),
    .slots_i (p_q),
    .match_o (rs2Match)
  );

  fpu_hazard_cmp #(.NSLOT(NSLOT), .RW(RW)) uCmpRd (
    .idx_i   (issue_rd),
    .slots_i (p_q),
    .match_o (rdMatch)
  );

`ifdef FPU_SCHED_FWD_EN
  assign rawMask = {{(NSLOT-1){1'b1}}, 1'b0};
`else
  assign rawMask = '1;
`endif

  // Structural: the target slot would overwrite a live op shifting into it,
  // or the latency does not fit the slot chain. WAW: an older op to the same
  // register would retire after this one.
  always_comb begin
    structHaz = (int'(lat) >= NSLOT);
    wawHaz    = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      if (reg_write && p_q[k].v && (k == int'(lat) + 1)) structHaz = 1'b1;
      if (reg_write && rdMatch[k] && (k >= int'(lat) + 2)) wawHaz = 1'b1;
    end
  end

  assign rawHaz      = (use_rs1 & |(rs1Match & rawMask)) |
                       (use_rs2 & |(rs2Match & rawMask));
  assign issue_ready = ~(structHaz | rawHaz | wawHaz) & ~flush;
  assign accept      = issue_valid & issue_ready;

  // Slots advance one step per cycle; an accepted writer drops into the slot
  // matching its latency, and flush empties the whole chain.
  always_comb begin
    p_d = {slot_t'('0), p_q[NSLOT-1:1]};
    if (flush) begin
      p_d = '0;
    end else if (accept && reg_write) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (k == int'(lat)) p_d[k] = '{v: 1'b1, rd: RW_MAX'(issue_rd)};
      end
    end
  end

  // Slot chain register; reset drops every pending writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

  assign wb_valid = p_q[0].v;
  assign wb_rd    = p_q[0].rd[RW-1:0];

  // Busy scoreboard: one bit per register with any pending writeback.
  always_comb begin
    busy = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (p_q[k].v) busy[p_q[k].rd[RW-1:0]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_wb_sched.sv
// tb_fpu_wb_sched: directed scenarios followed by random issue traffic, all
// checked against a pending-writeback list keyed by due cycle.
// Define FPU_SCHED_FWD_EN to build against the forwarding variant.
module tb_fpu_wb_sched;

  localparam int NSLOT = 4;
  localparam int RW    = 5;

  logic            clk = 1'b0;
  logic            rstN;
  logic            issueValid, useRs1, useRs2, regWrite, flush;
  logic [RW-1:0]   issueRd, issueRs1, issueRs2;
  logic [1:0]      issueLat;
  logic            issueReady, wbValid;
  logic [RW-1:0]   wbRd;
  logic [2**RW-1:0] busy;

  int errors = 0;
  int checks = 0;

  // Reference model: each accepted writer is remembered with the cycle in
  // which it must appear on the writeback port.
  typedef struct { int rd; int due; } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  bit    fwd;

  bit               expReady, expWbValid;
  int               expWbRd;
  logic [2**RW-1:0] expBusy;
  logic             lastObsReady;

  fpu_wb_sched #(.NSLOT(NSLOT), .RW(RW)) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .issue_valid (issueValid),
    .issue_rd    (issueRd),
    .issue_rs1   (issueRs1),
    .issue_rs2   (issueRs2),
    .use_rs1     (useRs1),
    .use_rs2     (useRs2),
    .reg_write   (regWrite),
    .lat         (issueLat),
    .flush       (flush),
    .issue_ready (issueReady),
    .wb_valid    (wbValid),
    .wb_rd       (wbRd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Derive expected outputs from the pending list and the presented op,
  // using the distance (due - now) of each pending writer.
  function automatic void modelEval();
    bit s, r, w;
    s = (int'(issueLat) >= NSLOT);
    r = 1'b0;
    w = 1'b0;
    expWbValid = 1'b0;
    expWbRd    = 0;
    expBusy    = '0;
    foreach (pend[i]) begin
      int d;
      d = pend[i].due - cyc;
      expBusy[pend[i].rd] = 1'b1;
      if (d == 0) begin
        expWbValid = 1'b1;
        expWbRd    = pend[i].rd;
      end
      if (regWrite && d == int'(issueLat) + 1) s = 1'b1;
      if (useRs1 && int'(issueRs1) == pend[i].rd && (d >= 1 || !fwd)) r = 1'b1;
      if (useRs2 && int'(issueRs2) == pend[i].rd && (d >= 1 || !fwd)) r = 1'b1;
      if (regWrite && int'(issueRd) == pend[i].rd && d >= int'(issueLat) + 2) w = 1'b1;
    end
    expReady = !(s || r || w) && !flush;
  endfunction

  // Advance the model across one rising edge.
  task automatic modelEdge();
    if (!rstN || flush) begin
      pend.delete();
    end else if (issueValid && expReady && regWrite) begin
      pend.push_back('{int'(issueRd), cyc + 1 + int'(issueLat)});
    end
    cyc++;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due < cyc) pend.delete(i);
    end
  endtask

  task automatic checkOutput(input string tag);
    modelEval();
    lastObsReady = issueReady;
    checks++;
    assert (issueReady === expReady) else begin
      errors++;
      $error("FAIL %s issue_ready: observed=%b expected=%b", tag, issueReady, expReady);
    end
    checks++;
    assert (wbValid === expWbValid) else begin
      errors++;
      $error("FAIL %s wb_valid: observed=%b expected=%b", tag, wbValid, expWbValid);
    end
    if (expWbValid) begin
      checks++;
      assert (wbRd === RW'(expWbRd)) else begin
        errors++;
        $error("FAIL %s wb_rd: observed=%0d expected=%0d", tag, wbRd, expWbRd);
      end
    end
    checks++;
    assert (busy === expBusy) else begin
      errors++;
      $error("FAIL %s busy: observed=%h expected=%h", tag, busy, expBusy);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check mid-cycle, then
  // let the rising edge happen and update the model.
  task automatic applyStimulus(input string tag, input logic v, input int rd,
                               input int rs1, input int rs2, input logic u1,
                               input logic u2, input logic rw, input int lt,
                               input logic fl);
    @(negedge clk);
    issueValid = v;
    issueRd    = RW'(rd);
    issueRs1   = RW'(rs1);
    issueRs2   = RW'(rs2);
    useRs1     = u1;
    useRs2     = u2;
    regWrite   = rw;
    issueLat   = 2'(lt);
    flush      = fl;
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Hold an op on the issue port until accepted, then compare the number of
  // cycles the DUT refused it against the stall count the scenario implies.
  task automatic issueOp(input string tag, input int rd, input int rs1, input int rs2,
                         input logic u1, input logic u2, input logic rw, input int lt,
                         input int expStalls);
    int  stalls;
    bit  done;
    stalls = 0;
    done   = 1'b0;
    for (int t = 0; t < 8 && !done; t++) begin
      applyStimulus(tag, 1'b1, rd, rs1, rs2, u1, u2, rw, lt, 1'b0);
      if (lastObsReady !== 1'b1) stalls++;
      done = expReady;
    end
    checks++;
    assert (done && stalls == expStalls) else begin
      errors++;
      $error("FAIL %s stall_cycles: observed=%0d expected=%0d", tag, stalls, expStalls);
    end
  endtask

  // Drop reset in the middle of a low clock phase and check the outputs
  // clear without waiting for an edge.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    issueValid = 1'b0;
    useRs1     = 1'b0;
    useRs2     = 1'b0;
    regWrite   = 1'b0;
    flush      = 1'b0;
    #1 rstN = 1'b0;
    #1 pend.delete();
    checkOutput(tag);
    checks++;
    assert (wbRd === '0) else begin
      errors++;
      $error("FAIL %s wb_rd_reset: observed=%0d expected=0", tag, wbRd);
    end
    @(posedge clk);
    modelEdge();
  endtask

  initial begin
`ifdef FPU_SCHED_FWD_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    rstN = 1'b0;
    issueValid = 1'b0; issueRd = '0; issueRs1 = '0; issueRs2 = '0;
    useRs1 = 1'b0; useRs2 = 1'b0; regWrite = 1'b0; issueLat = '0; flush = 1'b0;

    // Reset state: outputs low, ready follows only flush.
    applyStimulus("rst_idle", 1'b1, 4, 0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    checks++;
    assert (wbRd === '0) else begin
      errors++;
      $error("FAIL rst_wb_rd: observed=%0d expected=0", wbRd);
    end
    applyStimulus("rst_flush", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    #2 rstN = 1'b1;

    // Mult to r5: busy while in flight, writeback after two more edges.
    issueOp("mult_r5", 5, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    idleCycles("mult_r5_wait", 4);

    // RAW on a mult result: forwarding saves one stall cycle.
    issueOp("raw_mult", 3, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    issueOp("raw_add", 10, 3, 0, 1'b1, 1'b0, 1'b1, 1, fwd ? 2 : 3);
    idleCycles("raw_drain", 4);

    // RAW on rs2 from a non-writing op is still checked.
    issueOp("raw2_mult", 6, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    issueOp("raw2_store", 0, 1, 6, 1'b1, 1'b1, 1'b0, 0, fwd ? 2 : 3);
    idleCycles("raw2_drain", 4);

    // Structural: a load right behind an add collides for one cycle.
    issueOp("st_add", 8, 0, 0, 1'b0, 1'b0, 1'b1, 1, 0);
    issueOp("st_load", 9, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1);
    idleCycles("st_drain", 4);

    // WAW: a load to the same register waits for the mult to retire.
    issueOp("waw_mult", 7, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    issueOp("waw_load", 7, 0, 0, 1'b0, 1'b0, 1'b1, 0, 2);
    idleCycles("waw_drain", 4);

    // Flush with three writers in flight: nothing accepted, nothing retires.
    issueOp("fl_a", 1, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    issueOp("fl_b", 2, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    issueOp("fl_c", 3, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    applyStimulus("fl_flush", 1'b1, 4, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    idleCycles("fl_after", 3);

    // Reset in mid-flight: outputs clear at once and nothing retires later.
    issueOp("rs_a", 12, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    issueOp("rs_b", 13, 0, 0, 1'b0, 1'b0, 1'b1, 3, 0);
    pulseReset("rs_pulse");
    applyStimulus("rs_hold", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    #2 rstN = 1'b1;
    idleCycles("rs_after", 4);

    // Random traffic over a small register range to provoke every hazard.
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) != 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 19) == 0));
    end
    idleCycles("final_drain", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_wb_sched.md
FPU_WB_SCHED -- requirements
Module: fpu_wb_sched

Interface
REQ-001 SHALL have parameter NSLOT, default 4: number of writeback slots; the maximum supported latency is NSLOT-1.
REQ-002 SHALL have parameter RW, default 5: FP register index width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port issue_valid, input, 1: a decoded FP op is presented.
REQ-006 SHALL have port issue_rd, input, RW: destination register.
REQ-007 SHALL have port issue_rs1 / issue_rs2, input, RW each: source registers.
REQ-008 SHALL have port use_rs1 / use_rs2, input, 1 each: the corresponding source is read.
REQ-009 SHALL have port reg_write, input, 1: the op writes the FP register file.
REQ-010 SHALL have port lat, input, 2: latency class (0 = load/cvif class, 1 = add/sub, 2 = mult, 3 = reserved).
REQ-011 SHALL have port flush, input, 1: discard all pending writebacks.
REQ-012 SHALL have port issue_ready, output, 1: the op is accepted this cycle; combinational.
REQ-013 SHALL have port wb_valid, output, 1: a writeback occurs this cycle.
REQ-014 SHALL have port wb_rd, output, RW: register being written back.
REQ-015 SHALL have port busy, output, 2**RW: one-hot OR of all pending destinations.

Function
REQ-016 SHALL hold slots p[0..NSLOT-1], each {v, rd}; on every edge p[k] <= p[k+1] and p[NSLOT-1] <= 0.
REQ-017 SHALL treat accept as issue_valid & issue_ready; on accept with reg_write=1, p[lat] <= {1, issue_rd}, overriding the shifted value.
REQ-018 SHALL drive wb_valid = p[0].v and wb_rd = p[0].rd; an op accepted at edge t SHALL therefore write back in the cycle following edge t+lat.
REQ-019 SHALL detect a structural hazard when reg_write & p[lat+1].v; there SHALL be no structural hazard for lat = NSLOT-1.
REQ-020 SHALL detect a RAW hazard when a used source equals p[k].rd for any valid k>=1; a match at k=0 SHALL also be a hazard unless forwarding is enabled (REQ-030).
REQ-021 SHALL detect a WAW hazard when reg_write is set and issue_rd equals p[k].rd for any valid k>=lat+2.
REQ-022 SHALL drive issue_ready = ~(structural | RAW | WAW) & ~flush.
REQ-023 SHALL allocate no slot for an accepted op with reg_write=0; such an op SHALL still be subject to RAW checking.
REQ-024 SHALL, when flush=1 at an edge, clear all p[k].v and accept nothing; wb_valid SHALL be 0 in the following cycle.
REQ-025 SHALL ignore a lat value of 3 when NSLOT=3 (reserved) and SHALL treat it as a structural hazard, holding issue_ready at 0.
REQ-026 SHALL compute busy combinationally from all valid slots, including p[0].

Reset
REQ-027 SHALL, while rst_n=0, clear all slot valid bits and rd fields asynchronously.
REQ-028 SHALL, in reset, produce wb_valid=0, wb_rd=0 and busy=0; issue_ready SHALL depend only on flush.
REQ-029 SHALL, on reset mid-operation, lose pending writebacks with no writeback issued.

Configuration
REQ-030 SHALL, with FPU_SCHED_FWD_EN defined, not treat a RAW match against p[0] as a hazard, because the writeback value is forwarded that cycle; without the macro, a p[0] match SHALL stall.

Structure
REQ-031 SHALL place the slot struct, the latency-class constants (LAT_LOAD=0, LAT_ADSB=1, LAT_MULT=2) and NSLOT in the shared package fpu_pkg.
REQ-032 SHALL instantiate one sub-module fpu_hazard_cmp, which compares one RW-bit index against all slots and returns a per-slot match vector; it SHALL be instantiated for rs1, rs2 and rd.

Verification
REQ-033 SHALL cover: accept rd=5 with lat=2 -> wb_valid=1 with wb_rd=5 exactly 3 cycles after the accept edge, and busy[5]=1 meanwhile.
REQ-034 SHALL cover: mult rd=3 (lat=2), then next cycle an add (lat=1) with rs1=3 -> issue_ready=0 until p[0] holds rd 3 (with FWD_EN) or until one cycle after the writeback (without it).
REQ-035 SHALL cover: add lat=1 accepted, then immediately lat=0 rd≠ -> structural hazard, issue_ready=0 for one cycle.
REQ-036 SHALL cover: mult rd=7 lat=2, then next cycle load rd=7 lat=0 -> WAW stall until the mult writes back.
REQ-037 SHALL cover: flush with 3 pending slots -> wb_valid=0 and busy=0 from the next cycle.
REQ-038 SHALL cover: rst_n pulsed low mid-sequence -> all outputs 0 immediately, and no writeback after release.
